// File: rtl/tl_fifo_order_seq.sv
// Per-group FIFO-domain ordering sequencer for the TileLink A/D handshake path.
// Optional stall-cycle counter is enabled by defining TL_FIFO_ORDER_SEQ_PERF_EN.
module tl_fifo_order_seq #(
    parameter int          GROUP_SHIFT = 2,
    parameter int          CNT_W       = 3,
    parameter logic [30:0] DOMAIN_MASK = 31'h4000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_a_valid,
    output logic        in_a_ready,
    input  logic [2:0]  in_a_opcode,
    input  logic [2:0]  in_a_size,
    input  logic [4:0]  in_a_source,
    input  logic [30:0] in_a_address,
    output logic        out_a_valid,
    input  logic        out_a_ready,
    input  logic        d_valid,
    input  logic        d_ready,
    input  logic [2:0]  d_opcode,
    input  logic [2:0]  d_size,
    input  logic [4:0]  d_source,
    output logic        stall
`ifdef TL_FIFO_ORDER_SEQ_PERF_EN
    ,
    input  logic        perf_clear,
    output logic [31:0] perf_stall_cycles
`endif
);

    localparam int SRC_W = 5;
    localparam int GW    = SRC_W - GROUP_SHIFT;
    localparam int NG    = 1 << GW;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Remaining beats after a first beat on a 64-bit bus (size 7 -> 15).
    function automatic logic [3:0] beats_m1(input logic data, input logic [2:0] size);
        logic [4:0] b;
        b = 5'd1;
        if (data && size > 3'd3) b = 5'd1 << (size - 3'd3);
        return 4'(b - 5'd1);
    endfunction

    logic [NG-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NG-1:0]            dom_q, dom_d;
    logic [3:0]               a_cnt_q, a_cnt_d;
    logic [3:0]               d_cnt_q, d_cnt_d;

    logic [GW-1:0] ga, gd;
    logic          dom_a, a_first, a_fire, a_data;
    logic          d_fire, d_data, d_last;
    logic          unused_src_bits;

    assign ga              = in_a_source[SRC_W-1:GROUP_SHIFT];
    assign gd              = d_source[SRC_W-1:GROUP_SHIFT];
    assign unused_src_bits = ^{in_a_source[GROUP_SHIFT-1:0], d_source[GROUP_SHIFT-1:0]};
    assign dom_a           = |(in_a_address & DOMAIN_MASK);
    assign a_first         = (a_cnt_q == 4'd0);
    assign a_data          = (in_a_opcode <= 3'd3);
    assign d_data          = (d_opcode == 3'd1) || (d_opcode == 3'd5);

    // Stall only looks at registered counts, so a domain switch waits one cycle after the last D beat.
    assign stall = in_a_valid && a_first &&
                   (((cnt_q[ga] != '0) && (dom_q[ga] != dom_a)) || (cnt_q[ga] == CNT_MAX));

    assign out_a_valid = in_a_valid & ~stall;
    assign in_a_ready  = out_a_ready & ~stall;
    assign a_fire      = in_a_valid & in_a_ready;
    assign d_fire      = d_valid & d_ready;
    assign d_last      = d_fire && ((d_cnt_q == 4'd1) ||
                                    ((d_cnt_q == 4'd0) && (beats_m1(d_data, d_size) == 4'd0)));

    always_comb begin
        a_cnt_d = a_cnt_q;
        d_cnt_d = d_cnt_q;
        cnt_d   = cnt_q;
        dom_d   = dom_q;
        if (a_fire) a_cnt_d = a_first ? beats_m1(a_data, in_a_size) : a_cnt_q - 4'd1;
        if (d_fire) d_cnt_d = (d_cnt_q == 4'd0) ? beats_m1(d_data, d_size) : d_cnt_q - 4'd1;
        for (int g = 0; g < NG; g++) begin
            logic inc, dec;
            inc = a_fire && a_first && (ga == GW'(g));
            dec = d_last && (gd == GW'(g));
            if (inc) dom_d[g] = dom_a;
            // Decrement at zero is a protocol error; the count holds instead of wrapping.
            if (inc && !dec && cnt_q[g] != CNT_MAX) cnt_d[g] = cnt_q[g] + CNT_W'(1);
            else if (dec && !inc && cnt_q[g] != '0) cnt_d[g] = cnt_q[g] - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            dom_q   <= '0;
            a_cnt_q <= '0;
            d_cnt_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            dom_q   <= dom_d;
            a_cnt_q <= a_cnt_d;
            d_cnt_q <= d_cnt_d;
        end
    end

`ifdef TL_FIFO_ORDER_SEQ_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (perf_clear) perf_d = '0;
        else if (stall && perf_q != 32'hFFFF_FFFF) perf_d = perf_q + 32'd1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) perf_q <= '0;
        else        perf_q <= perf_d;
    end

    assign perf_stall_cycles = perf_q;
`endif

endmodule
